// File: rtl/matrix_load_seq.sv
// Streams a 4x4 A then 4x4 B matrix into the multiplier operand memory, then starts and waits for one multiply.
// Define LOAD_TIMEOUT_EN to abandon the wait after TIMEOUT_CYCLES cycles with an err pulse.
module matrix_load_seq #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              mm_start,
  input  logic              mm_done,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t     state;
  logic [4:0] idx;
  logic       accept;

  assign accept = in_valid && in_ready;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 5'd0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= 4'd0;
      wr_data   <= '0;
      mm_start  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      err       <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      wr_en     <= 1'b0;
      mm_start  <= 1'b0;
      load_done <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      err       <= 1'b0;
`endif
      // Accepted element is written one cycle later; index bit 4 selects A/B.
      if (accept) begin
        wr_en   <= 1'b1;
        wr_data <= in_data;
        wr_addr <= idx[3:0];
        wr_sel  <= idx[4];
        idx     <= idx + 5'd1;
      end

      case (state)
        IDLE: begin
          if (go) begin
            state    <= LOAD_A;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD_A: begin
          if (accept && idx == 5'd15) begin
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          // mm_start lines up with the final B write.
          if (accept && idx == 5'd31) begin
            state    <= START;
            in_ready <= 1'b0;
            mm_start <= 1'b1;
          end
        end
        START: begin
          state <= WAIT;
`ifdef LOAD_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mm_done) begin
            state     <= FIN;
            load_done <= 1'b1;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= 5'd0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          idx   <= 5'd0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
          idx      <= 5'd0;
        end
      endcase
    end
  end

endmodule
